pspin_cmd_id_alloc: RTL and testbench
=====================================

PSPIN_CMD_ID_ALLOC -- requirements
Module: pspin_cmd_id_alloc

Interface
REQ-001 SHALL have parameter NUM_CLUSTERS, default 4, number of clusters (cluster ID width CW = clog2(NUM_CLUSTERS)).
REQ-002 SHALL have parameter NUM_CORES, default 8, number of HPUs served (core ID width KW = clog2(NUM_CORES)).
REQ-003 SHALL have parameter NUM_HPU_CMDS, default 4, command slots per core, power of 2, >=2 (local ID width LW = clog2(NUM_HPU_CMDS)).
REQ-004 SHALL have parameter RR_POLICY, default 0: 0 = lowest-free-index allocation; 1 = per-core round-robin allocation.
REQ-005 SHALL have parameter CNT_W, default clog2(NUM_HPU_CMDS+1), per-core in-flight counter width.
REQ-006 SHALL have port clk_i, input, 1 bit, single clock, rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit, reset, asynchronous, active-low.
REQ-008 SHALL have port cluster_id_i, input, CW bits, this cluster's ID, quasi-static.
REQ-009 SHALL have port alloc_valid_i, input, NUM_CORES bits, per-core ID request.
REQ-010 SHALL have port alloc_ready_o, output, NUM_CORES bits, per-core free slot available.
REQ-011 SHALL have port alloc_id_o, output, NUM_CORES x (CW+KW+LW) bits, offered ID {cluster_id, core_id, local_cmd_id}.
REQ-012 SHALL have port resp_valid_i, input, 1 bit, command completion.
REQ-013 SHALL have port resp_id_i, input, CW+KW+LW bits, completed command ID, same packing.
REQ-014 SHALL have port inflight_o, output, NUM_CORES x CNT_W bits, busy slots per core.
REQ-015 SHALL have port idle_o, output, NUM_CORES bits, core has zero busy slots.
REQ-016 SHALL have port err_o, output, 1 bit, one-cycle pulse on an illegal response.

Function
REQ-017 SHALL hold per core a busy bitmap of NUM_HPU_CMDS bits and, when RR_POLICY=1, a LW-bit next pointer.
REQ-018 SHALL drive alloc_ready_o[c] combinationally = OR of ~busy[c], independent of alloc_valid_i[c].
REQ-019 RR_POLICY=0: alloc_id_o[c] local field SHALL be the lowest-index free slot of core c.
REQ-020 RR_POLICY=1: local field SHALL be the first free slot at or after next pointer, searching upward with wrap at NUM_HPU_CMDS-1 -> 0.
REQ-021 alloc_id_o[c] SHALL carry cluster_id_i and constant core field c; it SHALL be don't-care while alloc_ready_o[c]=0.
REQ-022 alloc_valid_i[c] & alloc_ready_o[c] SHALL set the offered slot busy at the next edge; in RR mode next pointer SHALL become (slot+1) mod NUM_HPU_CMDS.
REQ-023 All cores SHALL allocate independently and concurrently in the same cycle; no inter-core arbitration.
REQ-024 resp_valid_i with matching cluster field and busy target slot SHALL clear that slot at the next edge.
REQ-025 resp_valid_i with cluster field != cluster_id_i, core field >= NUM_CORES, or non-busy target slot SHALL change no state and SHALL assert err_o exactly one cycle later.
REQ-026 Simultaneous alloc and response on the same core SHALL both take effect; the slot freed SHALL NOT be offered in that cycle (no bypass), offer is computed from pre-edge state.
REQ-027 inflight_o[c] SHALL equal popcount(busy[c]) of registered state; idle_o[c] SHALL equal (inflight_o[c]==0).
REQ-028 Full core (all slots busy): alloc_ready_o[c]=0, alloc_valid_i[c] SHALL be ignored, valid may stay asserted.
REQ-029 Allocation latency: zero cycles (ID valid in request cycle); slot reuse after response: one cycle.

Reset
REQ-030 rst_ni low SHALL asynchronously clear all busy bitmaps, RR pointers to 0, err_o to 0; hence alloc_ready_o all 1, inflight_o all 0, idle_o all 1.
REQ-031 Reset mid-operation SHALL discard all in-flight IDs; responses for pre-reset IDs SHALL subsequently flag err_o per REQ-025.

Verification
REQ-032 Defaults, cluster_id_i=2, RR_POLICY=0: core 3 requests 4 consecutive cycles -> IDs local 0,1,2,3 with core 3, cluster 2; cycle 5 alloc_ready_o[3]=0, inflight_o[3]=4, idle_o[3]=0.
REQ-033 Core 3 full; response {2,3,1} -> next cycle alloc_ready_o[3]=1, offered local 1, inflight_o[3]=3; err_o stays 0.
REQ-034 RR_POLICY=1: core 0 allocs slots 0,1; free 0; next alloc -> local 2, then 3, then 0 (wrap).
REQ-035 Response {1,0,0} with cluster_id_i=2, or {2,5,2} with slot idle -> no state change, err_o high exactly one cycle.
REQ-036 Core 4 full, same cycle response frees slot 2 and alloc_valid_i[4]=1 -> no allocation that cycle; next cycle offered local 2 accepted.
REQ-037 All 8 cores allocate same cycle, then rst_ni asserted mid-cycle -> outputs immediately per REQ-030 without clock edge.

Source files
------------

// File: rtl/pspin_cmd_id_alloc.sv
// pspin_cmd_id_alloc: per-core command ID allocator with busy bitmaps and response-driven release
module pspin_cmd_id_alloc #(
    parameter int NUM_CLUSTERS = 4,
    parameter int NUM_CORES    = 8,
    parameter int NUM_HPU_CMDS = 4,
    parameter int RR_POLICY    = 0,
    parameter int CNT_W        = $clog2(NUM_HPU_CMDS + 1),
    localparam int CW          = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1,
    localparam int KW          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int LW          = $clog2(NUM_HPU_CMDS),
    localparam int IDW         = CW + KW + LW
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [CW-1:0]                    cluster_id_i,
    input  logic [NUM_CORES-1:0]             alloc_valid_i,
    output logic [NUM_CORES-1:0]             alloc_ready_o,
    output logic [NUM_CORES-1:0][IDW-1:0]    alloc_id_o,
    input  logic                             resp_valid_i,
    input  logic [IDW-1:0]                   resp_id_i,
    output logic [NUM_CORES-1:0][CNT_W-1:0]  inflight_o,
    output logic [NUM_CORES-1:0]             idle_o,
    output logic                             err_o
);
    logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0] busy_q, busy_d;
    logic [NUM_CORES-1:0][LW-1:0]           ptr_q, ptr_d, slot;
    logic                                   err_q, err_d;
    logic [CW-1:0]                          resp_cl;
    logic [KW-1:0]                          resp_core;
    logic [LW-1:0]                          resp_slot;
    logic                                   resp_ok;

    assign {resp_cl, resp_core, resp_slot} = resp_id_i;
    assign resp_ok = resp_valid_i && (resp_cl == cluster_id_i)
                     && ({1'b0, resp_core} < (KW+1)'(NUM_CORES))
                     && busy_q[resp_core][resp_slot];
    assign err_o = err_q;

    // Offer the first free slot at or after the pointer (pointer stays 0 in lowest-index mode)
    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            slot[c] = '0;
            for (int i = NUM_HPU_CMDS - 1; i >= 0; i--)
                if (!busy_q[c][ptr_q[c] + LW'(i)]) slot[c] = ptr_q[c] + LW'(i);
            alloc_ready_o[c] = ~&busy_q[c];
            alloc_id_o[c]    = {cluster_id_i, KW'(c), slot[c]};
        end
    end

    // Occupancy and idle status straight from the registered bitmaps
    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            inflight_o[c] = '0;
            for (int i = 0; i < NUM_HPU_CMDS; i++)
                inflight_o[c] = inflight_o[c] + CNT_W'(busy_q[c][i]);
            idle_o[c] = ~|busy_q[c];
        end
    end

    // Next state: set accepted slots, clear the released slot, flag illegal responses
    always_comb begin
        busy_d = busy_q;
        ptr_d  = ptr_q;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (alloc_valid_i[c] && alloc_ready_o[c]) begin
                busy_d[c][slot[c]] = 1'b1;
                ptr_d[c]           = (RR_POLICY != 0) ? LW'(slot[c] + 1'b1) : '0;
            end
        end
        if (resp_ok) busy_d[resp_core][resp_slot] = 1'b0;
        err_d = resp_valid_i && !resp_ok;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            ptr_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_pspin_cmd_id_alloc.sv
// tb_pspin_cmd_id_alloc: checks lowest-index and round-robin allocators against a slot-list model
module tb_pspin_cmd_id_alloc;
    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           cid = 2'd2;
    logic [7:0]           av = '0;
    logic                 rv = 1'b0;
    logic [6:0]           rid = '0;
    logic [7:0]           rdy [2];
    logic [7:0][6:0]      aid [2];
    logic [7:0][2:0]      inf [2];
    logic [7:0]           idl [2];
    logic                 err [2];
    int                   tests = 0;
    int                   fails = 0;
    bit                   mb [2][8][4];
    int                   mp [2][8];
    bit                   me [2];

    always #5 clk = ~clk;

    pspin_cmd_id_alloc #(.RR_POLICY(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cluster_id_i(cid), .alloc_valid_i(av),
        .alloc_ready_o(rdy[0]), .alloc_id_o(aid[0]), .resp_valid_i(rv), .resp_id_i(rid),
        .inflight_o(inf[0]), .idle_o(idl[0]), .err_o(err[0]));

    pspin_cmd_id_alloc #(.RR_POLICY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cluster_id_i(cid), .alloc_valid_i(av),
        .alloc_ready_o(rdy[1]), .alloc_id_o(aid[1]), .resp_valid_i(rv), .resp_id_i(rid),
        .inflight_o(inf[1]), .idle_o(idl[1]), .err_o(err[1]));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Slot a core would be handed: lowest free, or first free scanning from the RR pointer
    function automatic int offer(int d, int c);
        int s = (d == 1) ? mp[d][c] : 0;
        for (int k = 0; k < 4; k++)
            if (!mb[d][c][(s + k) % 4]) return (s + k) % 4;
        return -1;
    endfunction

    function automatic int used(int d, int c);
        int n = 0;
        for (int k = 0; k < 4; k++) n += int'(mb[d][c][k]);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                me[d] = 1'b0;
                for (int c = 0; c < 8; c++) begin
                    mp[d][c] = 0;
                    for (int k = 0; k < 4; k++) mb[d][c][k] = 1'b0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int  o [8];
                bit  legal;
                for (int c = 0; c < 8; c++) o[c] = offer(d, c);
                legal = rv && (rid[6:5] == cid) && mb[d][rid[4:2]][rid[1:0]];
                for (int c = 0; c < 8; c++)
                    if (av[c] && o[c] >= 0) begin
                        mb[d][c][o[c]] = 1'b1;
                        mp[d][c] = (o[c] + 1) % 4;
                    end
                if (legal) mb[d][rid[4:2]][rid[1:0]] = 1'b0;
                me[d] = rv && !legal;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 8; c++) begin
                    int o;
                    o = offer(d, c);
                    chk("ready", 32'(rdy[d][c]), 32'(o >= 0));
                    if (o >= 0) chk("alloc_id", 32'(aid[d][c]), 32'(cid * 32 + c * 4 + o));
                    chk("inflight", 32'(inf[d][c]), 32'(used(d, c)));
                    chk("idle", 32'(idl[d][c]), 32'(used(d, c) == 0));
                end
                chk("err", 32'(err[d]), 32'(me[d]));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_ready", 32'(rdy[0]), 32'hFF);
        chk("rst_idle", 32'(idl[0]), 32'hFF);
        chk("rst_inflight", 32'(inf[0]), 32'h0);
        chk("rst_err", 32'(err[0]), 32'h0);
        av = 8'h08;
        for (int k = 0; k < 4; k++) begin
            chk("core3_id", 32'(aid[0][3]), 32'(76 + k));
            cyc();
        end
        chk("core3_full_ready", 32'(rdy[0][3]), 32'h0);
        chk("core3_full_inflight", 32'(inf[0][3]), 32'd4);
        chk("core3_full_idle", 32'(idl[0][3]), 32'h0);
        cyc();
        chk("core3_held_inflight", 32'(inf[0][3]), 32'd4);
        av = '0;
        rv = 1'b1;
        rid = 7'd77;
        cyc();
        rv = 1'b0;
        chk("free_ready", 32'(rdy[0][3]), 32'h1);
        chk("free_id", 32'(aid[0][3]), 32'd77);
        chk("free_inflight", 32'(inf[0][3]), 32'd3);
        chk("free_err", 32'(err[0]), 32'h0);
        av = 8'h10;
        repeat (4) cyc();
        chk("core4_full", 32'(rdy[0][4]), 32'h0);
        rv = 1'b1;
        rid = 7'd82;
        cyc();
        rv = 1'b0;
        chk("nobypass_ready", 32'(rdy[0][4]), 32'h1);
        chk("nobypass_id", 32'(aid[0][4]), 32'd82);
        chk("nobypass_inflight", 32'(inf[0][4]), 32'd3);
        cyc();
        chk("reuse_inflight", 32'(inf[0][4]), 32'd4);
        chk("reuse_ready", 32'(rdy[0][4]), 32'h0);
        av = '0;
        rv = 1'b1;
        rid = 7'd32;
        cyc();
        rv = 1'b0;
        chk("bad_cluster_err", 32'(err[0]), 32'h1);
        chk("bad_cluster_state", 32'(inf[0][0]), 32'h0);
        cyc();
        chk("bad_cluster_err_drop", 32'(err[0]), 32'h0);
        rv = 1'b1;
        rid = 7'd86;
        cyc();
        rv = 1'b0;
        chk("idle_slot_err", 32'(err[0]), 32'h1);
        cyc();
        chk("idle_slot_err_drop", 32'(err[0]), 32'h0);
        av = 8'h01;
        chk("rr_id0", 32'(aid[1][0]), 32'd64);
        cyc();
        chk("rr_id1", 32'(aid[1][0]), 32'd65);
        cyc();
        av = '0;
        rv = 1'b1;
        rid = 7'd64;
        cyc();
        rv = 1'b0;
        chk("rr_after_free", 32'(aid[1][0]), 32'd66);
        chk("low_after_free", 32'(aid[0][0]), 32'd64);
        av = 8'h01;
        cyc();
        chk("rr_next3", 32'(aid[1][0]), 32'd67);
        cyc();
        chk("rr_wrap0", 32'(aid[1][0]), 32'd64);
        cyc();
        av = '0;
        chk("rr_full", 32'(rdy[1][0]), 32'h0);
        chk("rr_full_inflight", 32'(inf[1][0]), 32'd4);
        av = 8'hFF;
        cyc();
        av = '0;
        chk("all_core7", 32'(inf[0][7]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", 32'(rdy[0]), 32'hFF);
        chk("async_idle", 32'(idl[0]), 32'hFF);
        chk("async_inflight", 32'(inf[0]), 32'h0);
        chk("async_err", 32'(err[0]), 32'h0);
        chk("async_ready_rr", 32'(rdy[1]), 32'hFF);
        cyc();
        rst_n = 1'b1;
        rv = 1'b1;
        rid = 7'd77;
        cyc();
        rv = 1'b0;
        chk("stale_id_err", 32'(err[0]), 32'h1);
        for (int n = 0; n < 300; n++) begin
            av = 8'($urandom);
            rv = 1'($urandom);
            rid = {($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2, 5'($urandom)};
            cyc();
        end
        av = '0;
        rv = 1'b0;
        cyc();
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
